instr_mem_loader: RTL and testbench

- Instruction-side responder for the single-cycle RISC-V core.
- Answers the core's PC fetch with a 32-bit Instr word from on-chip instruction memory.
- Also owns the boot path: a byte-stream loader fills the memory while the core is held in reset, then releases the core.
- Sits between the core's PC/Instr port and the board-level program source (UART receiver or testbench).

---
 rtl/instr_mem_loader.sv | 153 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction-side responder for a single-cycle RISC-V core.
// It answers PC fetches from on-chip instruction memory with zero-cycle latency.
// It also owns the boot path: a little-endian byte-stream loader fills the memory
// while the core is held in reset, and then releases the core.
module instr_mem_loader #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter bit          START_RUN = 1'b0,
   parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       PC,
   output logic [31:0]       Instr,
   output logic              cpu_reset,
   input  logic              load_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              loading,
   output logic              load_done,
   output logic [ADDR_W:0]   words_loaded,
   output logic              overflow_err
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StRun} state_e;

   localparam state_e           ResetState = START_RUN ? StRun : StIdle;
   localparam logic             ResetCpu   = START_RUN ? 1'b0 : 1'b1;
   localparam logic [ADDR_W:0]  DepthCnt   = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       asm_q, asm_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic              ovf_q, ovf_d;
   logic              cpu_reset_q, cpu_reset_d;

   logic [31:0]       mem_q [DEPTH];

   logic              start;
   logic              accept;
   logic              word_wr;
   logic              mem_we;
   logic [31:0]       asm_merged;
   logic [ADDR_W-1:0] fetch_idx;
   logic              pc_in_range;
   logic              unused_pc;

   // load_start counts only where ld_ready is low and a load may begin.
   assign start   = load_start && ((state_q == StIdle) || (state_q == StRun));
   assign accept  = (state_q == StLoad) && ld_valid;
   // A word is written on the fourth byte, or early on ld_last (zero padded).
   assign word_wr = accept && ((byte_cnt_q == 2'd3) || ld_last);
   // A write with the pointer parked at DEPTH is an overflow and is dropped.
   assign mem_we  = word_wr && (wr_ptr_q != DepthCnt);

   // The assembly register is cleared after every word, so the upper bytes are
   // already zero when a short final word is written.
   assign asm_merged = asm_q | ({24'b0, ld_data} << {byte_cnt_q, 3'b000});

   assign fetch_idx   = PC[ADDR_W+1:2];
   assign pc_in_range = (PC[31:ADDR_W+2] == '0);
   assign unused_pc   = ^PC[1:0];

   // State register, with an asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ResetState;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the load ends on ld_last, and DONE lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (load_start) state_d = StLoad;
         StLoad:  if (accept && ld_last) state_d = StDone;
         StDone:  state_d = StRun;
         StRun:   if (load_start) state_d = StLoad;
         default: state_d = ResetState;
      endcase
   end

   // Moore outputs and the fetch mux; cpu_reset follows the next state.
   always_comb begin
      ld_ready    = (state_q == StLoad);
      loading     = (state_q == StLoad);
      load_done   = (state_q == StDone);
      cpu_reset_d = (state_d != StRun);
      Instr       = NOP_WORD;
      if ((state_q == StRun) && pc_in_range) begin
         Instr = mem_q[fetch_idx];
      end
   end

   // Next-state logic for the loader datapath (byte lane, pointer, overflow flag).
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      wr_ptr_d   = wr_ptr_q;
      ovf_d      = ovf_q;
      if (start) begin
         byte_cnt_d = 2'd0;
         asm_d      = 32'd0;
         wr_ptr_d   = '0;
         ovf_d      = 1'b0;
      end else if (accept) begin
         byte_cnt_d = ld_last ? 2'd0 : byte_cnt_q + 2'd1;
         asm_d      = word_wr ? 32'd0 : asm_merged;
         if (word_wr) begin
            if (wr_ptr_q == DepthCnt) begin
               ovf_d = 1'b1;
            end else begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
      end
   end

   // Loader datapath registers; an asynchronous reset aborts any load in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt_q  <= 2'd0;
         asm_q       <= 32'd0;
         wr_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         cpu_reset_q <= ResetCpu;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         wr_ptr_q    <= wr_ptr_d;
         ovf_q       <= ovf_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   // Instruction memory: write-only from the loader and never reset, so
   // contents survive reloads and resets.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= asm_merged;
      end
   end

   assign cpu_reset    = cpu_reset_q;
   assign words_loaded = wr_ptr_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: three instances share one stimulus stream.
//   a: DEPTH=256, START_RUN=0   b: DEPTH=4, START_RUN=0   c: DEPTH=256, START_RUN=1
// Expected memory contents come from a byte-image model that packs each loaded
// image into words.
module tb_instr_mem_loader;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        load_start, ld_valid, ld_last;
   logic [7:0]  ld_data;

   logic [31:0] instr_a, instr_b, instr_c;
   logic        cpu_reset_a, cpu_reset_b, cpu_reset_c;
   logic        ld_ready_a, ld_ready_b, ld_ready_c;
   logic        loading_a, loading_b, loading_c;
   logic        load_done_a, load_done_b, load_done_c;
   logic [8:0]  words_loaded_a, words_loaded_c;
   logic [2:0]  words_loaded_b;
   logic        overflow_err_a, overflow_err_b, overflow_err_c;

   always #5 clk = ~clk;

   instr_mem_loader #(.DEPTH(256), .ADDR_W(8), .START_RUN(1'b0)) u_a (
      .clk(clk), .reset(reset), .PC(pc), .Instr(instr_a), .cpu_reset(cpu_reset_a),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready_a), .loading(loading_a), .load_done(load_done_a),
      .words_loaded(words_loaded_a), .overflow_err(overflow_err_a));

   instr_mem_loader #(.DEPTH(4), .ADDR_W(2), .START_RUN(1'b0)) u_b (
      .clk(clk), .reset(reset), .PC(pc), .Instr(instr_b), .cpu_reset(cpu_reset_b),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready_b), .loading(loading_b), .load_done(load_done_b),
      .words_loaded(words_loaded_b), .overflow_err(overflow_err_b));

   instr_mem_loader #(.DEPTH(256), .ADDR_W(8), .START_RUN(1'b1)) u_c (
      .clk(clk), .reset(reset), .PC(pc), .Instr(instr_c), .cpu_reset(cpu_reset_c),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready_c), .loading(loading_c), .load_done(load_done_c),
      .words_loaded(words_loaded_c), .overflow_err(overflow_err_c));

   int nvec = 0;
   int nfail = 0;

   // Reference model. Instances a and c see identical writes, so they share one model.
   logic [31:0] mdl_a [256];
   bit          known_a [256];
   logic [31:0] mdl_b [4];
   bit          known_b [4];
   int          exp_wl_a, exp_wl_b;
   bit          exp_ovf_a, exp_ovf_b;
   logic [7:0]  img_q [$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pack the committed image into words: the model's view of memory after a load.
   task automatic commit_image();
      int n = img_q.size();
      int nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         logic [31:0] word = 32'd0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < n) word[8*k +: 8] = img_q[4*w+k];
         end
         if (w < 256) begin mdl_a[w] = word; known_a[w] = 1'b1; end
         if (w < 4)   begin mdl_b[w] = word; known_b[w] = 1'b1; end
      end
      exp_wl_a  = (nw < 256) ? nw : 256;
      exp_wl_b  = (nw < 4) ? nw : 4;
      exp_ovf_a = (nw > 256);
      exp_ovf_b = (nw > 4);
   endtask

   // Load img_q with up to max_gap idle cycles between bytes, checking handshake,
   // DONE pulse and release of cpu_reset along the way.
   task automatic load_image(input int max_gap);
      // A byte offered in the start cycle (even flagged last) must not be taken.
      load_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hFF; ld_last = 1'b1;
      tick();
      load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      chk("start_loading_a", loading_a, 1);
      chk("start_cpu_reset_a", cpu_reset_a, 1);
      chk("start_cpu_reset_c", cpu_reset_c, 1);
      chk("start_words_a", words_loaded_a, 0);
      chk("start_words_b", words_loaded_b, 0);
      chk("start_ovf_b", overflow_err_b, 0);
      for (int i = 0; i < img_q.size(); i++) begin
         int gap = $urandom_range(max_gap, 0);
         repeat (gap) begin
            load_start = 1'($urandom_range(1, 0));
            tick();
            load_start = 1'b0;
         end
         ld_valid = 1'b1; ld_data = img_q[i]; ld_last = (i == img_q.size() - 1);
         chk("byte_ready_a", ld_ready_a, 1);
         chk("byte_ready_b", ld_ready_b, 1);
         tick();
         ld_valid = 1'b0; ld_last = 1'b0;
      end
      chk("done_pulse_a", load_done_a, 1);
      chk("done_pulse_b", load_done_b, 1);
      chk("done_cpu_reset_a", cpu_reset_a, 1);
      chk("done_instr_nop_a", instr_a, NOP);
      load_start = 1'($urandom_range(1, 0));
      tick();
      load_start = 1'b0;
      chk("run_done_low_a", load_done_a, 0);
      chk("run_cpu_reset_a", cpu_reset_a, 0);
      chk("run_cpu_reset_b", cpu_reset_b, 0);
      chk("run_ready_a", ld_ready_a, 0);
      commit_image();
      chk("words_a", words_loaded_a, exp_wl_a);
      chk("words_b", words_loaded_b, exp_wl_b);
      chk("ovf_a", overflow_err_a, exp_ovf_a);
      chk("ovf_b", overflow_err_b, exp_ovf_b);
   endtask

   // Fetch check against the model; words never written are skipped.
   task automatic check_pc(input logic [31:0] p);
      int ia = int'(p[9:2]);
      int ib = int'(p[3:2]);
      pc = p;
      #1;
      if (p[31:10] != 0) begin
         chk("fetch_oor_a", instr_a, NOP);
         chk("fetch_oor_c", instr_c, NOP);
      end else if (known_a[ia]) begin
         chk("fetch_a", instr_a, mdl_a[ia]);
         chk("fetch_c", instr_c, mdl_a[ia]);
      end
      if (p[31:4] != 0) chk("fetch_oor_b", instr_b, NOP);
      else if (known_b[ib]) chk("fetch_b", instr_b, mdl_b[ib]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h0000_0000, 32'h0050_0513, 32'h0050_0513};
      tbl[1] = '{32'h0000_0004, 32'h0010_0593, 32'h0010_0593};
      tbl[2] = '{32'h0000_0006, 32'h0010_0593, 32'h0010_0593};
      tbl[3] = '{32'h0000_0003, 32'h0050_0513, 32'h0050_0513};
      tbl[4] = '{32'h0000_0400, NOP,           NOP};
      tbl[5] = '{32'hFFFF_FFFC, NOP,           NOP};

      // Reset with ld_valid held high: the loader must not offer ready.
      reset = 1'b0; pc = 32'h0; load_start = 1'b0; ld_valid = 1'b1; ld_last = 1'b0;
      ld_data = 8'h00;
      repeat (3) tick();
      chk("rst_cpu_reset_a", cpu_reset_a, 1);
      chk("rst_cpu_reset_c", cpu_reset_c, 0);
      chk("rst_ready_a", ld_ready_a, 0);
      chk("rst_instr_a", instr_a, NOP);
      chk("rst_words_a", words_loaded_a, 0);
      chk("rst_ovf_a", overflow_err_a, 0);
      chk("rst_done_a", load_done_a, 0);
      reset = 1'b1;
      tick(); tick();
      chk("idle_cpu_reset_a", cpu_reset_a, 1);
      chk("idle_ready_a", ld_ready_a, 0);
      chk("idle_loading_a", loading_a, 0);
      pc = 32'h40; #1;
      chk("idle_instr_a", instr_a, NOP);
      chk("idle_words_a", words_loaded_a, 0);
      ld_valid = 1'b0;

      // Two-instruction program, then table-driven fetches.
      img_q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      load_image(0);
      chk("prog_words_a", words_loaded_a, 2);
      foreach (tbl[i]) begin
         pc = tbl[i].pc;
         #1;
         chk("tbl_a", instr_a, tbl[i].exp_a);
         chk("tbl_b", instr_b, tbl[i].exp_b);
         chk("tbl_c", instr_c, tbl[i].exp_a);
      end

      // Five-byte image: the trailing partial word is zero padded.
      img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      load_image(2);
      pc = 32'h0; #1; chk("pad_w0_a", instr_a, 32'hDDCCBBAA);
      pc = 32'h4; #1; chk("pad_w1_a", instr_a, 32'h000000EE);
      chk("pad_words_a", words_loaded_a, 2);

      // Twenty bytes: the DEPTH=4 instance overflows but keeps accepting.
      img_q.delete();
      for (int i = 0; i < 20; i++) img_q.push_back(8'(8'h10 + i));
      load_image(1);
      chk("ovf_flag_b", overflow_err_b, 1);
      chk("ovf_words_b", words_loaded_b, 4);
      chk("ovf_words_a", words_loaded_a, 5);
      pc = 32'h0;  #1; chk("ovf_w0_b", instr_b, 32'h13121110);
      pc = 32'hC;  #1; chk("ovf_w3_b", instr_b, 32'h1F1E1D1C);
      pc = 32'h10; #1; chk("ovf_pc16_b", instr_b, NOP);
      chk("ovf_pc16_a", instr_a, 32'h23222120);

      // Reload from RUN: flag cleared on start, untouched words keep old contents.
      img_q = '{8'h37, 8'h01, 8'h00, 8'h00};
      load_image(1);
      pc = 32'h0; #1; chk("reload_w0_a", instr_a, 32'h00000137);
      pc = 32'h4; #1; chk("reload_w1_a", instr_a, 32'h17161514);
      chk("reload_w1_b", instr_b, 32'h17161514);

      // Reset six bytes into a load: one word written, partial word lost.
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_data = 8'(i + 1); tick();
      end
      ld_data = 8'h07;
      #2 reset = 1'b0;
      #1;
      chk("abort_cpu_reset_a", cpu_reset_a, 1);
      chk("abort_ready_a", ld_ready_a, 0);
      chk("abort_loading_a", loading_a, 0);
      chk("abort_words_a", words_loaded_a, 0);
      chk("abort_cpu_reset_c", cpu_reset_c, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("abort_idle_ready_a", ld_ready_a, 0);
      chk("abort_idle_cpu_reset_a", cpu_reset_a, 1);
      ld_valid = 1'b0;
      mdl_a[0] = 32'h04030201; known_a[0] = 1'b1;
      mdl_b[0] = 32'h04030201; known_b[0] = 1'b1;
      pc = 32'h0; #1; chk("abort_w0_c", instr_c, 32'h04030201);
      pc = 32'h4; #1; chk("abort_w1_c", instr_c, 32'h17161514);

      // Random images and fetches against the model.
      for (int it = 0; it < 8; it++) begin
         int n = $urandom_range(24, 1);
         img_q.delete();
         for (int i = 0; i < n; i++) img_q.push_back(8'($urandom_range(255, 0)));
         load_image(2);
         for (int k = 0; k < 12; k++) begin
            logic [31:0] p;
            if ($urandom_range(3, 0) == 0) p = $urandom();
            else p = 32'($urandom_range(7, 0) * 4 + $urandom_range(3, 0));
            check_pc(p);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
